// File: rtl/banco_captura_rtc_pkg.sv
// Shared definitions for the RTC capture bank: FSM state encoding,
// funcion_conf mode encodings and the default per-mode skip masks.
package rtc_pkg;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PIDE    = 2'd1,
        CAPTURA = 2'd2,
        FIN     = 2'd3
    } estado_t;

    // funcion_conf encodings: which register group the user is editing.
    localparam logic [1:0] MODO_NORMAL = 2'b00;
    localparam logic [1:0] MODO_HORA   = 2'b01;
    localparam logic [1:0] MODO_FECHA  = 2'b10;
    localparam logic [1:0] MODO_TIMER  = 2'b11;

    // Default skip masks for the standard 10-register map.
    localparam logic [9:0] MASK_HORA_DEF  = 10'b0000000111; // sec/min/hour
    localparam logic [9:0] MASK_FECHA_DEF = 10'b0001111000; // day/month/year/weekday
    localparam logic [9:0] MASK_TIMER_DEF = 10'b1110000000; // timer sec/min/hour

endpackage

// File: rtl/banco_captura_rtc_buscador_siguiente.sv
// Combinational finder: returns the lowest register index >= inicio whose
// skip-mask bit is clear, plus a flag telling whether such an index exists.
module buscador_siguiente #(
    parameter int NUM_REG = 10,
    parameter int ADDR_W  = 4
) (
    input  logic [NUM_REG-1:0] mascara,
    input  logic [ADDR_W:0]    inicio,
    output logic [ADDR_W-1:0]  indice,
    output logic               encontrado
);

    // Scan from the top down so the last hit kept is the lowest eligible index.
    always_comb begin
        indice     = '0;
        encontrado = 1'b0;
        for (int i = NUM_REG - 1; i >= 0; i--) begin
            if (!mascara[i] && ((ADDR_W+1)'(i) >= inicio)) begin
                indice     = ADDR_W'(i);
                encontrado = 1'b1;
            end
        end
    end

endmodule

// File: rtl/banco_captura_rtc.sv
// Sequenced capture bank for the RTC local register map. On iniciar it sweeps
// the map, reading every register not in the group being edited over a
// req/ack handshake and writing the byte into a shadow register.
// Optional feature: define RTC_BCD_CHECK_EN to reject non-BCD data (the
// register is left untouched and the sticky error_bcd flag is raised).
//
// Handshake: rd_req is high for every PIDE cycle and addr_mem_local is stable
// while it is high. A cycle with rd_req=1 and rd_ack=1 completes the transfer
// and dato_rtc is sampled on that edge; rd_ack is ignored when rd_req=0.
module banco_captura_rtc
    import rtc_pkg::*;
#(
    parameter int               NUM_REG    = 10,
    parameter int               DATA_W     = 8,
    parameter int               ADDR_W     = 4,
    parameter logic [NUM_REG-1:0] MASK_HORA  = MASK_HORA_DEF,
    parameter logic [NUM_REG-1:0] MASK_FECHA = MASK_FECHA_DEF,
    parameter logic [NUM_REG-1:0] MASK_TIMER = MASK_TIMER_DEF,
    parameter int               TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                funcion_conf,
    input  logic                      iniciar,
    output logic                      rd_req,
    output logic [ADDR_W-1:0]         addr_mem_local,
    input  logic                      rd_ack,
    input  logic [DATA_W-1:0]         dato_rtc,
    output logic [NUM_REG-1:0]        hold,
    output logic [NUM_REG*DATA_W-1:0] regs_out,
    output logic                      ocupado,
    output logic                      fin,
    output logic                      timeout,
    output logic                      error_bcd,
    output logic [1:0]                estado_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    estado_t                   state, state_next;
    logic [NUM_REG-1:0]        mask_q;
    logic [NUM_REG-1:0]        mask_sel;
    logic [ADDR_W-1:0]         addr_q;
    logic [DATA_W-1:0]         dato_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [NUM_REG*DATA_W-1:0] regs_q;
    logic [ADDR_W:0]           busca_inicio;
    logic [ADDR_W-1:0]         busca_idx;
    logic                      busca_ok;
    logic                      tmo_hit;
    logic                      dato_ok;
    logic                      escribe;

    function automatic logic [NUM_REG-1:0] mascara_modo(input logic [1:0] modo);
        case (modo)
            MODO_HORA:  return MASK_HORA;
            MODO_FECHA: return MASK_FECHA;
            MODO_TIMER: return MASK_TIMER;
            default:    return '0;
        endcase
    endfunction

    // Finder inputs: in IDLE search from 0 with the mask about to be latched,
    // in CAPTURA search above the current address with the latched mask.
    always_comb begin
        mask_sel     = (state == IDLE) ? mascara_modo(funcion_conf) : mask_q;
        busca_inicio = '0;
        if (state == CAPTURA) begin
            busca_inicio = {1'b0, addr_q} + (ADDR_W+1)'(1);
        end
    end

    buscador_siguiente #(
        .NUM_REG (NUM_REG),
        .ADDR_W  (ADDR_W)
    ) u_buscador (
        .mascara    (mask_sel),
        .inicio     (busca_inicio),
        .indice     (busca_idx),
        .encontrado (busca_ok)
    );

    // The last tolerated wait cycle without ack aborts the sweep.
    assign tmo_hit = (state == PIDE) && !rd_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef RTC_BCD_CHECK_EN
    // Latched data is acceptable only if every nibble is a decimal digit.
    always_comb begin
        dato_ok = 1'b1;
        for (int k = 0; k < DATA_W / 4; k++) begin
            if (dato_q[k*4 +: 4] > 4'd9) begin
                dato_ok = 1'b0;
            end
        end
    end
`else
    assign dato_ok = 1'b1;
`endif

    assign escribe = (state == CAPTURA) && dato_ok;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (iniciar) begin
                    state_next = busca_ok ? PIDE : FIN;
                end
            end
            PIDE: begin
                if (rd_ack) begin
                    state_next = CAPTURA;
                end else if (tmo_hit) begin
                    state_next = IDLE;
                end
            end
            CAPTURA: begin
                state_next = busca_ok ? PIDE : FIN;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sweep datapath: skip mask, request address, wait counter, data latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
            dato_q <= '0;
        end else begin
            if (state == IDLE && iniciar) begin
                mask_q <= mask_sel;
            end
            if (state_next == PIDE && state != PIDE) begin
                addr_q <= busca_idx;
                cnt_q  <= '0;
            end else if (state == PIDE && !rd_ack) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state == PIDE && rd_ack) begin
                dato_q <= dato_rtc;
            end
        end
    end

    // Shadow registers: written on the edge that ends the CAPTURA cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else if (escribe) begin
            regs_q[addr_q*DATA_W +: DATA_W] <= dato_q;
        end
    end

    // Registered status outputs, aligned with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ocupado <= 1'b0;
            fin     <= 1'b0;
            timeout <= 1'b0;
        end else begin
            ocupado <= (state_next != IDLE);
            fin     <= (state_next == FIN);
            timeout <= tmo_hit;
        end
    end

`ifdef RTC_BCD_CHECK_EN
    // Sticky BCD error: cleared when a new sweep starts, set on rejected data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_bcd <= 1'b0;
        end else if (state == IDLE && iniciar) begin
            error_bcd <= 1'b0;
        end else if (state == CAPTURA && !dato_ok) begin
            error_bcd <= 1'b1;
        end
    end
`else
    assign error_bcd = 1'b0;
`endif

    // Active-low write strobe for the register being captured this cycle.
    always_comb begin
        hold = '1;
        if (escribe) begin
            hold[addr_q] = 1'b0;
        end
    end

    assign rd_req         = (state == PIDE);
    assign addr_mem_local = addr_q;
    assign regs_out       = regs_q;
    assign estado_dbg     = state;

endmodule
